// File: rtl/irq_controller_pkg.sv
// ============================================================================
// irq_controller_pkg : register offsets and FSM encoding shared by the
//                      interrupt controller files.          Rev 1.0
// ============================================================================
`default_nettype none

package irq_controller_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/irq_controller_sync_edge.sv
// ============================================================================
// irq_sync_edge : two-flop synchroniser with rising-edge detect for one
//                 asynchronous interrupt source.             Rev 1.0
// ============================================================================
`default_nettype none

module irq_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = async_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// irq_controller : fixed-priority external interrupt arbiter driving meip,
//                  with claim/complete register interface.    Rev 1.0
// ============================================================================
`default_nettype none

module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               ack_i,
  output logic               meip_o,
  input  logic               sel_i,
  input  logic               wen_i,
  input  logic [1:0]         addr_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]  data_o
);

  localparam logic [ID_W-1:0] ID_NONE = '1;

  logic [NUM_SRC-1:0] level_w;
  logic [NUM_SRC-1:0] rise_w;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .async_i (irq_src_i[g]),
      .level_o (level_w[g]),
      .rise_o  (rise_w[g])
    );
  end

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic               meip_q, meip_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [NUM_SRC-1:0] candidate;
  logic [NUM_SRC-1:0] winner_oh;
  logic [ID_W-1:0]    winner_id;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] w1c_clr;
  logic               wr, rd, take, complete;
  logic [DATA_W-1:0]  rdata;
  logic               unused_data;

  assign unused_data = ^data_i;
  assign candidate   = pending_q & enable_q;
  assign wr          = sel_i & wen_i;
  assign rd          = sel_i & ~wen_i;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    winner_oh = '0;
    winner_id = ID_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (candidate[i]) begin
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
        winner_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    meip_d     = 1'b0;
    take       = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        meip_d = |candidate;
        if (ack_i) begin
          if (|candidate) begin
            take       = 1'b1;
            claim_id_d = winner_id;
            meip_d     = 1'b0;
            state_d    = ST_ACTIVE;
          end else begin
            claim_id_d = ID_NONE;
          end
        end
      end
      ST_ACTIVE: begin
        if (wr && addr_i == ADDR_CLAIM && data_i[ID_W-1:0] == claim_id_q) begin
          complete   = 1'b1;
          claim_id_d = ID_NONE;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge-mode pending is sticky until claimed or W1C; a fresh rise wins.
  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    claim_clr = take ? winner_oh : '0;
    w1c_clr   = (wr && addr_i == ADDR_PENDING) ? data_i[NUM_SRC-1:0] : '0;
    if (wr && addr_i == ADDR_ENABLE) enable_d = data_i[NUM_SRC-1:0];
    if (wr && addr_i == ADDR_MODE)   mode_d   = data_i[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i]) begin
        pending_d[i] = rise_w[i] | (pending_q[i] & ~(claim_clr[i] | w1c_clr[i]));
      end else begin
        pending_d[i] = level_w[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr_i)
      ADDR_ENABLE:  rdata[NUM_SRC-1:0] = enable_q;
      ADDR_MODE:    rdata[NUM_SRC-1:0] = mode_q;
      ADDR_PENDING: rdata[NUM_SRC-1:0] = pending_q;
      default: begin
        rdata[DATA_W-1] = (state_q == ST_ACTIVE);
        rdata[ID_W-1:0] = claim_id_q;
      end
    endcase
    data_d = rd ? rdata : data_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      mode_q     <= '0;
      pending_q  <= '0;
      claim_id_q <= ID_NONE;
      meip_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      claim_id_q <= claim_id_d;
      meip_q     <= meip_d;
      data_q     <= data_d;
    end
  end

  assign meip_o = meip_q;
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// tb_irq_controller : directed self-checking bench for irq_controller.
//                                                             Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_controller;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  irq_src_i = '0;
  logic        ack_i = 1'b0;
  logic        meip_o;
  logic        sel_i = 1'b0;
  logic        wen_i = 1'b0;
  logic [1:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(.NUM_SRC(8), .ID_W(5)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .irq_src_i (irq_src_i),
    .ack_i     (ack_i),
    .meip_o    (meip_o),
    .sel_i     (sel_i),
    .wen_i     (wen_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    sel_i = 1'b1; wen_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    sel_i = 1'b0; wen_i = 1'b0; data_i = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    sel_i = 1'b1; wen_i = 1'b0; addr_i = a;
    @(posedge clk_i); #1;
    sel_i = 1'b0;
    d = data_o;
  endtask

  task automatic pulse_src(input logic [7:0] mask);
    @(posedge clk_i); #1;
    irq_src_i = irq_src_i | mask;
    @(posedge clk_i); #1;
    irq_src_i = irq_src_i & ~mask;
  endtask

  task automatic do_ack();
    @(posedge clk_i); #1;
    ack_i = 1'b1;
    @(posedge clk_i); #1;
    ack_i = 1'b0;
  endtask

  task automatic wait_meip(input int max, output int cycles);
    cycles = 0;
    while (meip_o !== 1'b1 && cycles < max) begin
      @(posedge clk_i); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #3 reset_i = 1'b0;
    #1;
    n_checks++;
    if (meip_o !== 1'b0) begin n_fail++; $display("FAIL reset_meip got=%0b want=0", meip_o); end
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h want=00000000", data_o); end
    #10 reset_i = 1'b1;
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0000_001F) begin n_fail++; $display("FAIL reset_claim got=%h want=0000001f", r); end
    reg_read(2'd0, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reset_enable got=%h want=00000000", r); end
  endtask

  task automatic test_edge_basic();
    logic [31:0] r;
    int c;
    reg_write(2'd0, 32'h01);
    reg_write(2'd1, 32'h01);
    pulse_src(8'h01);
    wait_meip(6, c);
    n_checks++;
    if (meip_o !== 1'b1 || c != 3) begin
      n_fail++; $display("FAIL edge_latency meip=%0b cycles=%0d want meip=1 cycles=3", meip_o, c);
    end
    do_ack();
    n_checks++;
    if (meip_o !== 1'b0) begin n_fail++; $display("FAIL edge_meip_after_ack got=%0b want=0", meip_o); end
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL edge_claim got=%h want=80000000", r); end
    reg_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL edge_pending got=%h want=00000000", r); end
    reg_write(2'd3, 32'h0);
  endtask

  task automatic test_priority();
    logic [31:0] r;
    int c;
    reg_write(2'd0, 32'h24);
    reg_write(2'd1, 32'h24);
    pulse_src(8'h24);
    wait_meip(8, c);
    n_checks++;
    if (meip_o !== 1'b1) begin n_fail++; $display("FAIL prio_meip got=%0b want=1", meip_o); end
    do_ack();
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h8000_0002) begin n_fail++; $display("FAIL prio_claim_first got=%h want=80000002", r); end
    reg_write(2'd3, 32'h2);
    wait_meip(4, c);
    n_checks++;
    if (meip_o !== 1'b1) begin n_fail++; $display("FAIL prio_reassert got=%0b want=1", meip_o); end
    do_ack();
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h8000_0005) begin n_fail++; $display("FAIL prio_claim_second got=%h want=80000005", r); end
    reg_write(2'd3, 32'h5);
    reg_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL prio_pending got=%h want=00000000", r); end
  endtask

  task automatic test_level_complete();
    logic [31:0] r;
    int c;
    reg_write(2'd1, 32'h00);
    reg_write(2'd0, 32'h08);
    @(posedge clk_i); #1 irq_src_i[3] = 1'b1;
    wait_meip(8, c);
    n_checks++;
    if (meip_o !== 1'b1) begin n_fail++; $display("FAIL level_meip got=%0b want=1", meip_o); end
    do_ack();
    reg_write(2'd3, 32'h4);
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h8000_0003 || meip_o !== 1'b0) begin
      n_fail++; $display("FAIL level_bad_id claim=%h meip=%0b want claim=80000003 meip=0", r, meip_o);
    end
    reg_write(2'd3, 32'h3);
    wait_meip(4, c);
    n_checks++;
    if (meip_o !== 1'b1) begin n_fail++; $display("FAIL level_reassert got=%0b want=1", meip_o); end
    reg_read(2'd2, r);
    n_checks++;
    if (r !== 32'h08) begin n_fail++; $display("FAIL level_pending got=%h want=00000008", r); end
    irq_src_i[3] = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (meip_o !== 1'b0) begin n_fail++; $display("FAIL level_drop got=%0b want=0", meip_o); end
  endtask

  task automatic test_vanish();
    logic [31:0] r;
    int c;
    reg_write(2'd0, 32'h02);
    @(posedge clk_i); #1 irq_src_i[1] = 1'b1;
    wait_meip(8, c);
    n_checks++;
    if (meip_o !== 1'b1) begin n_fail++; $display("FAIL vanish_meip_up got=%0b want=1", meip_o); end
    irq_src_i[1] = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (meip_o !== 1'b0) begin n_fail++; $display("FAIL vanish_meip_down got=%0b want=0", meip_o); end
    do_ack();
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0000_001F) begin n_fail++; $display("FAIL vanish_claim got=%h want=0000001f", r); end
  endtask

  task automatic test_masked_w1c();
    logic [31:0] r;
    reg_write(2'd0, 32'h00);
    reg_write(2'd1, 32'h40);
    pulse_src(8'h40);
    repeat (5) @(posedge clk_i);
    reg_read(2'd2, r);
    n_checks++;
    if (r !== 32'h40 || meip_o !== 1'b0) begin
      n_fail++; $display("FAIL mask_pending pend=%h meip=%0b want pend=00000040 meip=0", r, meip_o);
    end
    reg_write(2'd0, 32'h40);
    n_checks++;
    if (meip_o !== 1'b0) begin n_fail++; $display("FAIL mask_meip_early got=%0b want=0", meip_o); end
    @(posedge clk_i); #1;
    n_checks++;
    if (meip_o !== 1'b1) begin n_fail++; $display("FAIL mask_meip_enable got=%0b want=1", meip_o); end
    reg_write(2'd2, 32'h40);
    reg_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0 || meip_o !== 1'b0) begin
      n_fail++; $display("FAIL mask_w1c pend=%h meip=%0b want pend=00000000 meip=0", r, meip_o);
    end
  endtask

  task automatic test_reset_active();
    logic [31:0] r;
    int c;
    reg_write(2'd1, 32'h01);
    reg_write(2'd0, 32'h09);
    @(posedge clk_i); #1 irq_src_i[3] = 1'b1;
    pulse_src(8'h01);
    wait_meip(8, c);
    do_ack();
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pre_claim got=%h want=80000000", r); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    irq_src_i = '0;
    #1;
    n_checks++;
    if (meip_o !== 1'b0 || data_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_async meip=%0b data=%h want meip=0 data=00000000", meip_o, data_o);
    end
    #3 reset_i = 1'b1;
    reg_read(2'd3, r);
    n_checks++;
    if (r !== 32'h0000_001F) begin n_fail++; $display("FAIL rst_claim got=%h want=0000001f", r); end
    reg_read(2'd1, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rst_mode got=%h want=00000000", r); end
    reg_read(2'd2, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rst_pending got=%h want=00000000", r); end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_level_complete();
    test_vanish();
    test_masked_w1c();
    test_reset_active();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
